serial_tx_block: RTL and testbench

- Parallel-in, serial-out frame transmitter; the driving end of a single-wire serial link whose receiver samples one data bit per clock edge into a register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it on one output: start bit (0), WIDTH data bits LSB first, stop bit (1).
- Used in clock-detection and timing tests as a realistic sequential source: FSM, bit counter, baud divider and shift register, all in one clock domain.

---
 rtl/serial_tx_block.sv | 135 +++++++++++++
 tb/tb_serial_tx_block.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_block.sv
`default_nettype none
// ============================================================================
// serial_tx_block : framed parallel-to-serial transmitter (start, LSB-first
//                   data, stop) with valid/ready intake and baud divider.
// Revision 1.0
// ============================================================================
module serial_tx_block #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic             tx_q,    tx_d;
  logic             ready_q, ready_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             bit_tick;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    div_d    = div_q;
    tx_d     = tx_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bit_tick = (div_q == c_div_last);

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d = S_START;
          shift_d = data_in;
          div_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_d = S_DATA;
          div_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          div_d = '0;
          if (bit_q == c_bit_last) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            // Next data bit is presented from the freshly shifted register
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shift_d[0];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          state_d = S_IDLE;
          div_d   = '0;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_block.sv
`default_nettype none
// ============================================================================
// tb_serial_tx_block : scoreboard bench for serial_tx_block over three builds
//                      (8 bits / 1 clk, 8 bits / 4 clk, 1 bit / 1 clk).
// Revision 1.0
// ============================================================================
module tb_serial_tx_block;

  typedef struct {
    int           len;
    logic [127:0] bits;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [0:0] d2 = '0;
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic       rdy0, tx0, bsy0, dn0;
  logic       rdy1, tx1, bsy1, dn1;
  logic       rdy2, tx2, bsy2, dn2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [127:0] cap [3];
  int           clen [3];
  int           ndone [3];
  int           done_cyc [3];
  int           prev_done [3];
  string        nm [3] = '{"w8c1", "w8c4", "w1c1"};

  logic [2:0] m_tx, m_busy, m_done, m_rdy;
  assign m_tx   = {tx2, tx1, tx0};
  assign m_busy = {bsy2, bsy1, bsy0};
  assign m_done = {dn2, dn1, dn0};
  assign m_rdy  = {rdy2, rdy1, rdy0};

  serial_tx_block #(.WIDTH(8), .CLKS_PER_BIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .data_in(d0), .valid(v0),
    .ready(rdy0), .tx(tx0), .busy(bsy0), .done(dn0)
  );
  serial_tx_block #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(d1), .valid(v1),
    .ready(rdy1), .tx(tx1), .busy(bsy1), .done(dn1)
  );
  serial_tx_block #(.WIDTH(1), .CLKS_PER_BIT(1)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(d2), .valid(v2),
    .ready(rdy2), .tx(tx2), .busy(bsy2), .done(dn2)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_done(input int id, input int target);
    for (int k = 0; k < 300 && ndone[id] < target; k++) @(negedge clk);
    if (ndone[id] < target) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d done pulses expected %0d", nm[id], ndone[id], target);
    end
  endtask

  // Monitor: collects tx while busy, scores the frame when done pulses
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        cap[i]  = '0;
        clen[i] = 0;
      end else if (m_done[i]) begin
        ndone[i]++;
        prev_done[i] = done_cyc[i];
        done_cyc[i]  = cyc;
        have = 1'b0;
        case (i)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          check({nm[i], "_unexpected_done"}, 128'd1, 128'd0);
        end else begin
          check({nm[i], "_len"}, 128'(clen[i]), 128'(e.len));
          check({nm[i], "_bits"}, cap[i], e.bits);
          check({nm[i], "_rdy_tx_at_done"}, {126'd0, m_rdy[i], m_tx[i]}, 128'd3);
        end
        cap[i]  = '0;
        clen[i] = 0;
      end else if (m_busy[i]) begin
        if (clen[i] < 128) cap[i][clen[i]] = m_tx[i];
        clen[i]++;
      end
    end
  end

  initial begin
    int acc;
    for (int i = 0; i < 3; i++) begin
      cap[i] = '0; clen[i] = 0; ndone[i] = 0; done_cyc[i] = 0; prev_done[i] = 0;
    end

    // Asynchronous reset with no clock edge in between
    #2 rst = 1'b1;
    #1;
    check("rst_w8c1_outs", {124'd0, tx0, rdy0, bsy0, dn0}, 128'hC);
    check("rst_w8c4_outs", {124'd0, tx1, rdy1, bsy1, dn1}, 128'hC);
    check("rst_w1c1_outs", {124'd0, tx2, rdy2, bsy2, dn2}, 128'hC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_outs", {124'd0, tx0, rdy0, bsy0, dn0}, 128'hC);
    end

    // Single frame A5, data_in altered after accept
    q0.push_back('{10, 128'h34A});
    @(posedge clk); #1 d0 = 8'hA5; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    @(posedge clk); #1 d0 = 8'h00;
    wait_done(0, 1);

    // Divider build, 4 clocks per bit
    q1.push_back('{40, 128'hF0000000F0});
    @(posedge clk); #1 d1 = 8'h01; v1 = 1'b1;
    @(posedge clk); #1 acc = cyc; v1 = 1'b0;
    wait_done(1, 1);
    check("w8c4_done_latency", 128'(done_cyc[1] - acc), 128'd40);

    // Back-to-back FF then 00 with valid held high
    q0.push_back('{10, 128'h3FE});
    q0.push_back('{10, 128'h200});
    @(posedge clk); #1 d0 = 8'hFF; v0 = 1'b1;
    @(posedge clk); #1 d0 = 8'h00;
    for (int k = 0; k < 50 && !dn0; k++) @(negedge clk);
    @(posedge clk); #1 v0 = 1'b0;
    wait_done(0, 3);
    check("b2b_done_spacing", 128'(done_cyc[0] - prev_done[0]), 128'd11);

    // Reset during data bit 3 of 5A, then a clean 3C frame
    @(posedge clk); #1 d0 = 8'h5A; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midrst_outs", {124'd0, tx0, rdy0, bsy0, dn0}, 128'hC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q0.push_back('{10, 128'h278});
    @(posedge clk); #1 d0 = 8'h3C; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    wait_done(0, 4);

    // Single-bit build
    q2.push_back('{3, 128'h6});
    @(posedge clk); #1 d2 = 1'b1; v2 = 1'b1;
    @(posedge clk); #1 v2 = 1'b0;
    wait_done(2, 1);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 128'(q0.size() + q1.size() + q2.size()), 128'd0);
    check("done_count_total", 128'(ndone[0] + ndone[1] + ndone[2]), 128'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
